// File: rtl/bus_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arb_pkg
//  Brief    : Shared constants, FSM state type and one-hot helper for the
//             32-source bus grant arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    localparam int N_REQ  = 32;
    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // Expand a binary source index into the matching one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
        onehot       = '0;
        onehot[code] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_grant_arbiter_if
//  Brief    : Request/grant bundle between the control unit's request lines
//             and the bus multiplexer select. Suffixes are from the
//             arbiter's point of view.
//  Revision : 1.0 - initial release
// ============================================================================
interface bus_grant_arbiter_if;
    import bus_arb_pkg::*;

    logic [N_REQ-1:0]  req_i;
    logic              release_i;
    logic [N_REQ-1:0]  grant_o;
    logic [CODE_W-1:0] grant_code_o;
    logic              bus_busy_o;
    logic              timeout_o;

    // Arbiter side
    modport slave (
        input  req_i, release_i,
        output grant_o, grant_code_o, bus_busy_o, timeout_o
    );

    // Requester / bus-mux side
    modport master (
        output req_i, release_i,
        input  grant_o, grant_code_o, bus_busy_o, timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/bus_grant_arbiter_rr_mask_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mask_encoder
//  Brief    : Combinational winner selection. Highest set index wins; with
//             rotation enabled only indices below the last owner are tried
//             first, falling back to the full request set (wrap 0 -> 31).
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mask_encoder
    import bus_arb_pkg::*;
(
    input  logic [N_REQ-1:0]  req_i,
    input  logic [CODE_W-1:0] last_owner_i,
    input  logic              rr_en_i,
    output logic [CODE_W-1:0] winner_o,
    output logic              any_o
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_masked;

    // Index of the highest set bit; zero for an empty vector (never used).
    function automatic logic [CODE_W-1:0] hi_index(input logic [N_REQ-1:0] v);
        hi_index = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) hi_index = CODE_W'(i);
        end
    endfunction

    // Indices strictly below the last owner; empty when last owner is 0.
    assign w_mask   = (N_REQ'(1) << last_owner_i) - N_REQ'(1);
    assign w_masked = req_i & w_mask;
    assign any_o    = |req_i;

    // Prefer the rotated window, fall back to plain highest-index priority.
    always_comb begin
        winner_o = hi_index(req_i);
        if (rr_en_i && (|w_masked)) winner_o = hi_index(w_masked);
    end

endmodule
`default_nettype wire

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_grant_arbiter
//  Brief    : Grants the internal bus to one of 32 requesters. One-hot grant
//             plus binary select code, round-robin or fixed priority, a
//             bounded hold time and a one-cycle turnaround between owners.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_grant_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter bit RR_EN    = 1'b1
) (
    input  logic                  clock,
    input  logic                  clear,
    bus_grant_arbiter_if.slave    bus
);

    localparam logic [CODE_W-1:0] HOLD_LIMIT = CODE_W'(MAX_HOLD);
    localparam bit                HOLD_EN    = (MAX_HOLD != 0);

    state_t            state_q;
    logic [N_REQ-1:0]  grant_q;
    logic [CODE_W-1:0] code_q;
    logic              busy_q;
    logic              timeout_q;
    logic [CODE_W-1:0] last_owner_q;
    logic [CODE_W-1:0] hold_cnt_q;

    logic [CODE_W-1:0] w_winner;
    logic              w_any;
    logic              w_release;
    logic              w_withdraw;
    logic              w_expire;

    rr_mask_encoder u_enc (
        .req_i        (bus.req_i),
        .last_owner_i (last_owner_q),
        .rr_en_i      (RR_EN),
        .winner_o     (w_winner),
        .any_o        (w_any)
    );

    assign w_release  = bus.release_i;
    assign w_withdraw = ~bus.req_i[last_owner_q];
    assign w_expire   = HOLD_EN && (hold_cnt_q == HOLD_LIMIT);

    // Ownership FSM with registered grant, code, busy and timeout outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            code_q       <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            last_owner_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        state_q      <= OWN;
                        grant_q      <= onehot(w_winner);
                        code_q       <= w_winner;
                        busy_q       <= 1'b1;
                        last_owner_q <= w_winner;
                        hold_cnt_q   <= CODE_W'(1);
                    end
                end
                OWN: begin
                    if (hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + CODE_W'(1);
                    if (w_release || w_withdraw || w_expire) begin
                        state_q   <= TURN;
                        grant_q   <= '0;
                        code_q    <= '0;
                        busy_q    <= 1'b0;
                        // Only a pure timer expiry is reported as a revocation.
                        timeout_q <= w_expire && !w_release && !w_withdraw;
                    end
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_o      = grant_q;
    assign bus.grant_code_o = code_q;
    assign bus.bus_busy_o   = busy_q;
    assign bus.timeout_o    = timeout_q;

endmodule
`default_nettype wire
